mcyc_controller_p: RTL and testbench
====================================

Name: mcyc_controller_p

Overview:
- Parametrised multicycle control FSM for the byte-fetch TinyMIPS datapath; next generation of the fixed four-fetch controller.
- Generalised instruction width: FETCH_BEATS bytes fetched per instruction.
- Adds a memory-ready handshake (wait states), a BNE instruction, a corrected ADDI writeback and funct-decoded R-type ALU op.
- Sits between instruction register/opcode field and all datapath mux/enable controls.

Parameters:
- FETCH_BEATS, 4, bytes fetched per instruction; legal 1..8; width of irwrite.
- BEAT_W, 3, width of internal fetch-beat counter; must satisfy 2^BEAT_W >= FETCH_BEATS.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- op  in  6  opcode field of IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current read/write this cycle
- memread, memwrite  out  1  memory strobes
- alusrca, memtoreg, iord, regwrite, regdst  out  1  datapath selects/enables
- pcen  out  1  PC register enable
- pcsource, alusrcb, aluop  out  2  mux selects; aluop 00=add, 01=sub, 10=funct
- irwrite  out  FETCH_BEATS  one-hot IR byte-lane write enable
- illegal  out  1  illegal-opcode flag (only when ILLEGAL_TRAP_EN defined, otherwise tied 0)

Behaviour:
- Opcodes: LB=100000, SB=101000, RTYPE=000000, BEQ=100100, BNE=100101, J=100010, ADDI=001000.
- States: FETCH, DECODE, MEMADR, LBRD, LBWR, SBWR, RTYPEEX, RTYPEWR, BEQEX, BNEEX, JEX, ADDIWR, TRAP (macro only).
- Reset: while rst=1, state<=FETCH, beat<=0, and all outputs forced to 0 (incl. pcen, memread, irwrite). Reset mid-instruction abandons it; first fetch begins the cycle after rst falls.
- FETCH: memread=1, alusrca=0, alusrcb=01, aluop=00. If mem_ready=1: irwrite bit[beat]=1, pcen=1; beat increments; on beat==FETCH_BEATS-1, beat<=0 and go DECODE. If mem_ready=0: irwrite=0, pcen=0, hold state and beat.
- DECODE: alusrcb=11, aluop=00 (branch target precompute). Next: LB/SB/ADDI->MEMADR; RTYPE->RTYPEEX; BEQ->BEQEX; BNE->BNEEX; J->JEX; other->FETCH (treated as NOP), or TRAP with macro.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next: LB->LBRD, SB->SBWR, ADDI->ADDIWR.
- LBRD: memread=1, iord=1; hold until mem_ready=1, then LBWR.
- LBWR: regwrite=1, memtoreg=1, regdst=0; ->FETCH.
- SBWR: memwrite=1, iord=1; hold until mem_ready=1, then FETCH. memwrite stays high for every wait cycle.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10; ->RTYPEWR. RTYPEWR: regwrite=1, regdst=1, memtoreg=0; ->FETCH.
- ADDIWR: regwrite=1, regdst=0 (rt destination), memtoreg=0; alusrca=1, alusrcb=10, aluop=00 held; ->FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsource=01, pcen=zero. BNEEX: same but pcen=~zero. Both ->FETCH.
- JEX: pcsource=10, pcen=1; ->FETCH.
- pcen is combinational: (pcwrite) | (branch_eq & zero) | (branch_ne & ~zero); no glitch dependence on unused states.
- Unlisted outputs are 0 in every state. Unreachable state encodings -> FETCH.
- Latency with mem_ready tied 1 (FETCH_BEATS=4): R-type 7 cycles, LB 8, SB 7, ADDI 7, BEQ/BNE/J 6.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: unknown opcode in DECODE -> TRAP; TRAP asserts illegal=1, all other outputs 0, holds until rst.
- Undefined: unknown opcode -> FETCH silently; illegal tied 0; TRAP state absent.

Test Plan:
- FETCH_BEATS=4, mem_ready=1, op=000000 -> irwrite 0001,0010,0100,1000 on cycles 1-4, pcen=1 each, DECODE cycle 5, regwrite=1 regdst=1 on cycle 7.
- LB with mem_ready low 3 cycles during LBRD -> memread=iord=1 held 4 cycles, LBWR regwrite=1 memtoreg=1 exactly once.
- BEQ zero=1 -> pcen=1 pcsource=01 in BEQEX; zero=0 -> pcen=0. BNE zero=0 -> pcen=1; zero=1 -> pcen=0.
- mem_ready=0 during fetch beat 2 for 2 cycles -> irwrite=0, pcen=0 those cycles; beat resumes at 0100, no byte lane skipped or repeated.
- rst asserted during SBWR -> memwrite=0 same cycle, all outputs 0; after release FETCH beat 0 with irwrite=0001.
- FETCH_BEATS=2, op=111111: without ILLEGAL_TRAP_EN -> returns to FETCH after DECODE; with it -> illegal=1 held, no memread, until rst.

Source files
------------

// File: rtl/mcyc_controller_p.sv
// mcyc_controller_p
// Multicycle control FSM for the byte-fetch TinyMIPS datapath.
// Each instruction is fetched as FETCH_BEATS bytes, one IR byte lane per beat,
// with memory wait states signalled by i_mem_ready. After decode, the FSM walks
// the per-instruction sequence for LB, SB, R-type, ADDI, BEQ, BNE and J.
// Optional feature macro: ILLEGAL_TRAP_EN. When it is defined, an unknown
// opcode sends the FSM to a TRAP state. TRAP raises o_illegal and holds until
// rst. When it is undefined, an unknown opcode is a NOP and o_illegal is tied 0.
module mcyc_controller_p #(
  parameter int FETCH_BEATS = 4,
  parameter int BEAT_W      = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             i_op,
  input  logic                   i_zero,
  input  logic                   i_mem_ready,
  output logic                   o_memread,
  output logic                   o_memwrite,
  output logic                   o_alusrca,
  output logic                   o_memtoreg,
  output logic                   o_iord,
  output logic                   o_regwrite,
  output logic                   o_regdst,
  output logic                   o_pcen,
  output logic [1:0]             o_pcsource,
  output logic [1:0]             o_alusrcb,
  output logic [1:0]             o_aluop,
  output logic [FETCH_BEATS-1:0] o_irwrite,
  output logic                   o_illegal
);

  // Opcode field encodings
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b100100;
  localparam logic [5:0] OP_BNE   = 6'b100101;
  localparam logic [5:0] OP_J     = 6'b100010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Beat index of the final instruction byte
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FETCH_BEATS - 1);

  // ALU operation and mux select encodings
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BRT  = 2'b11;

  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_J   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_LBRD,
    S_LBWR,
    S_SBWR,
    S_RTYPEEX,
    S_RTYPEWR,
    S_BEQEX,
    S_BNEEX,
    S_JEX,
    S_ADDIWR
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [BEAT_W-1:0] r_beat;
  logic [BEAT_W-1:0] w_nextBeat;

  // Unconditional and conditional PC-write requests. o_pcen combines them with the zero flag.
  logic              w_pcwrite;
  logic              w_branchEq;
  logic              w_branchNe;

  // State and fetch-beat registers. Reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_beat  <= '0;
    end else begin
      r_state <= w_nextState;
      r_beat  <= w_nextBeat;
    end
  end

  // Next-state and next-beat selection
  always_comb begin
    w_nextState = S_FETCH;
    w_nextBeat  = '0;
    case (r_state)
      S_FETCH: begin
        w_nextState = S_FETCH;
        w_nextBeat  = r_beat;
        if (i_mem_ready) begin
          if (r_beat == LAST_BEAT) begin
            w_nextBeat  = '0;
            w_nextState = S_DECODE;
          end else begin
            w_nextBeat  = r_beat + BEAT_W'(1);
          end
        end
      end
      S_DECODE: begin
        case (i_op)
          OP_LB, OP_SB, OP_ADDI: w_nextState = S_MEMADR;
          OP_RTYPE:              w_nextState = S_RTYPEEX;
          OP_BEQ:                w_nextState = S_BEQEX;
          OP_BNE:                w_nextState = S_BNEEX;
          OP_J:                  w_nextState = S_JEX;
`ifdef ILLEGAL_TRAP_EN
          default:               w_nextState = S_TRAP;
`else
          default:               w_nextState = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        case (i_op)
          OP_LB:   w_nextState = S_LBRD;
          OP_SB:   w_nextState = S_SBWR;
          OP_ADDI: w_nextState = S_ADDIWR;
          default: w_nextState = S_FETCH;
        endcase
      end
      S_LBRD:    w_nextState = i_mem_ready ? S_LBWR : S_LBRD;
      S_LBWR:    w_nextState = S_FETCH;
      S_SBWR:    w_nextState = i_mem_ready ? S_FETCH : S_SBWR;
      S_RTYPEEX: w_nextState = S_RTYPEWR;
      S_RTYPEWR: w_nextState = S_FETCH;
      S_BEQEX:   w_nextState = S_FETCH;
      S_BNEEX:   w_nextState = S_FETCH;
      S_JEX:     w_nextState = S_FETCH;
      S_ADDIWR:  w_nextState = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:    w_nextState = S_TRAP;
`endif
      default:   w_nextState = S_FETCH;
    endcase
  end

  // Datapath control decode. Every output is held at 0 while rst is high.
  always_comb begin
    o_memread  = 1'b0;
    o_memwrite = 1'b0;
    o_alusrca  = 1'b0;
    o_memtoreg = 1'b0;
    o_iord     = 1'b0;
    o_regwrite = 1'b0;
    o_regdst   = 1'b0;
    o_pcsource = 2'b00;
    o_alusrcb  = SRCB_REG;
    o_aluop    = ALU_ADD;
    o_irwrite  = '0;
    w_pcwrite  = 1'b0;
    w_branchEq = 1'b0;
    w_branchNe = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    o_illegal  = 1'b0;
`endif
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          o_memread = 1'b1;
          o_alusrcb = SRCB_ONE;
          o_aluop   = ALU_ADD;
          if (i_mem_ready) begin
            w_pcwrite = 1'b1;
            for (int i = 0; i < FETCH_BEATS; i++) begin
              if (r_beat == BEAT_W'(i)) begin
                o_irwrite[i] = 1'b1;
              end
            end
          end
        end
        S_DECODE: begin
          o_alusrcb = SRCB_BRT;
          o_aluop   = ALU_ADD;
        end
        S_MEMADR: begin
          o_alusrca = 1'b1;
          o_alusrcb = SRCB_IMM;
          o_aluop   = ALU_ADD;
        end
        S_LBRD: begin
          o_memread = 1'b1;
          o_iord    = 1'b1;
        end
        S_LBWR: begin
          o_regwrite = 1'b1;
          o_memtoreg = 1'b1;
        end
        S_SBWR: begin
          o_memwrite = 1'b1;
          o_iord     = 1'b1;
        end
        S_RTYPEEX: begin
          o_alusrca = 1'b1;
          o_alusrcb = SRCB_REG;
          o_aluop   = ALU_FUNCT;
        end
        S_RTYPEWR: begin
          o_regwrite = 1'b1;
          o_regdst   = 1'b1;
        end
        S_BEQEX: begin
          o_alusrca  = 1'b1;
          o_alusrcb  = SRCB_REG;
          o_aluop    = ALU_SUB;
          o_pcsource = PCSRC_BR;
          w_branchEq = 1'b1;
        end
        S_BNEEX: begin
          o_alusrca  = 1'b1;
          o_alusrcb  = SRCB_REG;
          o_aluop    = ALU_SUB;
          o_pcsource = PCSRC_BR;
          w_branchNe = 1'b1;
        end
        S_JEX: begin
          o_pcsource = PCSRC_J;
          w_pcwrite  = 1'b1;
        end
        S_ADDIWR: begin
          o_regwrite = 1'b1;
          o_alusrca  = 1'b1;
          o_alusrcb  = SRCB_IMM;
          o_aluop    = ALU_ADD;
        end
`ifdef ILLEGAL_TRAP_EN
        S_TRAP: begin
          o_illegal = 1'b1;
        end
`endif
        default: begin
          o_memread = 1'b0;
        end
      endcase
    end
  end

  assign o_pcen = w_pcwrite | (w_branchEq & i_zero) | (w_branchNe & ~i_zero);

`ifndef ILLEGAL_TRAP_EN
  assign o_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mcyc_controller_p.sv
// tb_mcyc_controller_p
// Scoreboard bench for mcyc_controller_p with FETCH_BEATS=4. The driver issues
// whole instructions and pushes the control word expected on every cycle.
// A negedge monitor pops each expected word and compares it with the DUT.
// The bench follows ILLEGAL_TRAP_EN in the same way as the design.
module tb_mcyc_controller_p;

  localparam int FB = 4;
  localparam int BW = 3;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b100100;
  localparam logic [5:0] OP_BNE   = 6'b100101;
  localparam logic [5:0] OP_J     = 6'b100010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef struct packed {
    logic          memread;
    logic          memwrite;
    logic          alusrca;
    logic          memtoreg;
    logic          iord;
    logic          regwrite;
    logic          regdst;
    logic          pcen;
    logic [1:0]    pcsource;
    logic [1:0]    alusrcb;
    logic [1:0]    aluop;
    logic [FB-1:0] irwrite;
    logic          illegal;
  } ctrl_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    op = 6'b0;
  logic          zero = 1'b0;
  logic          memReady = 1'b0;
  logic          memread, memwrite, alusrca, memtoreg, iord, regwrite, regdst, pcen;
  logic [1:0]    pcsource, alusrcb, aluop;
  logic [FB-1:0] irwrite;
  logic          illegal;
  ctrl_t         actualOut;

  ctrl_t expQ[$];
  string tagQ[$];
  int    nChecks = 0;
  int    nFails  = 0;

  mcyc_controller_p #(.FETCH_BEATS(FB), .BEAT_W(BW)) dut (
    .clk(clk), .rst(rst), .i_op(op), .i_zero(zero), .i_mem_ready(memReady),
    .o_memread(memread), .o_memwrite(memwrite), .o_alusrca(alusrca),
    .o_memtoreg(memtoreg), .o_iord(iord), .o_regwrite(regwrite),
    .o_regdst(regdst), .o_pcen(pcen), .o_pcsource(pcsource),
    .o_alusrcb(alusrcb), .o_aluop(aluop), .o_irwrite(irwrite),
    .o_illegal(illegal)
  );

  always #5 clk = ~clk;

  always_comb actualOut = {memread, memwrite, alusrca, memtoreg, iord, regwrite,
                           regdst, pcen, pcsource, alusrcb, aluop, irwrite, illegal};

  function automatic logic rndBit();
    return logic'($urandom_range(1, 0));
  endfunction

  function automatic logic [5:0] rndOp();
    return 6'($urandom);
  endfunction

  function automatic bit isKnown(input logic [5:0] o);
    return (o == OP_LB) || (o == OP_SB) || (o == OP_RTYPE) || (o == OP_BEQ) ||
           (o == OP_BNE) || (o == OP_J) || (o == OP_ADDI);
  endfunction

  // Expected control word for one fetch cycle of byte lane 'beat'.
  function automatic ctrl_t fetchExp(input int beat, input bit rdy);
    ctrl_t e = '0;
    e.memread = 1'b1;
    e.alusrcb = 2'b01;
    if (rdy) begin
      e.irwrite[beat] = 1'b1;
      e.pcen = 1'b1;
    end
    return e;
  endfunction

  // Drive one clock cycle of inputs and record what the DUT must show during it.
  task automatic applyStimulus(input logic rstv, input logic [5:0] opv, input logic zv,
                               input logic rdyv, input ctrl_t e, input string tag);
    @(posedge clk);
    #1;
    rst = rstv;
    op = opv;
    zero = zv;
    memReady = rdyv;
    expQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  task automatic checkOutput(input string tag, input ctrl_t e);
    nChecks++;
    if (actualOut !== e) begin
      nFails++;
      $display("[TB] FAIL %s @%0t: got %b, expected %b", tag, $time, actualOut, e);
    end
  endtask

  // Monitor: compare mid-cycle, well away from the clock edge.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      checkOutput(tagQ.pop_front(), expQ.pop_front());
    end
  end

  // Fetch all FB byte lanes. Beat stallBeat waits stallCycles cycles. Other beats
  // wait a random 0..maxStall cycles. The op field is junk while fetching.
  task automatic doFetch(input int stallBeat, input int stallCycles, input int maxStall);
    int s;
    for (int b = 0; b < FB; b++) begin
      s = (b == stallBeat) ? stallCycles : int'($urandom_range(maxStall, 0));
      repeat (s) applyStimulus(1'b0, rndOp(), rndBit(), 1'b0, fetchExp(b, 1'b0), "fetchStall");
      applyStimulus(1'b0, rndOp(), rndBit(), 1'b1, fetchExp(b, 1'b1), "fetchBeat");
    end
  endtask

  task automatic doDecode(input logic [5:0] opv);
    ctrl_t e = '0;
    e.alusrcb = 2'b11;
    applyStimulus(1'b0, opv, rndBit(), rndBit(), e, "decode");
  endtask

  // Post-decode sequence of an instruction. memWaits is the number of wait cycles
  // for memory accesses. zForce is the zero flag at branch execute, or -1 for random.
  task automatic doExecute(input logic [5:0] opv, input int memWaits, input int zForce);
    ctrl_t e;
    logic  z;
    if (opv == OP_LB || opv == OP_SB || opv == OP_ADDI) begin
      e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
      applyStimulus(1'b0, opv, rndBit(), rndBit(), e, "memadr");
    end
    z = (zForce < 0) ? rndBit() : logic'(zForce);
    case (opv)
      OP_LB: begin
        e = '0; e.memread = 1'b1; e.iord = 1'b1;
        repeat (memWaits) applyStimulus(1'b0, opv, rndBit(), 1'b0, e, "lbReadWait");
        applyStimulus(1'b0, opv, rndBit(), 1'b1, e, "lbRead");
        e = '0; e.regwrite = 1'b1; e.memtoreg = 1'b1;
        applyStimulus(1'b0, opv, rndBit(), rndBit(), e, "lbWrite");
      end
      OP_SB: begin
        e = '0; e.memwrite = 1'b1; e.iord = 1'b1;
        repeat (memWaits) applyStimulus(1'b0, opv, rndBit(), 1'b0, e, "sbWait");
        applyStimulus(1'b0, opv, rndBit(), 1'b1, e, "sbWrite");
      end
      OP_ADDI: begin
        e = '0; e.regwrite = 1'b1; e.alusrca = 1'b1; e.alusrcb = 2'b10;
        applyStimulus(1'b0, opv, rndBit(), rndBit(), e, "addiWrite");
      end
      OP_RTYPE: begin
        e = '0; e.alusrca = 1'b1; e.aluop = 2'b10;
        applyStimulus(1'b0, opv, rndBit(), rndBit(), e, "rtypeEx");
        e = '0; e.regwrite = 1'b1; e.regdst = 1'b1;
        applyStimulus(1'b0, opv, rndBit(), rndBit(), e, "rtypeWrite");
      end
      OP_BEQ, OP_BNE: begin
        e = '0; e.alusrca = 1'b1; e.aluop = 2'b01; e.pcsource = 2'b01;
        e.pcen = (opv == OP_BEQ) ? z : ~z;
        applyStimulus(1'b0, opv, z, rndBit(), e, (opv == OP_BEQ) ? "beqEx" : "bneEx");
      end
      OP_J: begin
        e = '0; e.pcsource = 2'b10; e.pcen = 1'b1;
        applyStimulus(1'b0, opv, rndBit(), rndBit(), e, "jEx");
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        e = '0; e.illegal = 1'b1;
        repeat (4) applyStimulus(1'b0, rndOp(), rndBit(), rndBit(), e, "trapHold");
        applyStimulus(1'b1, rndOp(), rndBit(), rndBit(), ctrl_t'(0), "trapReset");
`else
        e = '0;
`endif
      end
    endcase
  endtask

  task automatic runInstr(input logic [5:0] opv, input int maxStall, input int memWaits,
                          input int zForce);
    doFetch(-1, 0, maxStall);
    doDecode(opv);
    doExecute(opv, memWaits, zForce);
  endtask

  // Time bound so the run always ends, even if the driver stops making progress.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d checks pending", expQ.size());
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [5:0] opTable[7];
    logic [5:0] opv;
    ctrl_t      e;
    opTable = '{OP_LB, OP_SB, OP_RTYPE, OP_BEQ, OP_BNE, OP_J, OP_ADDI};

    repeat (3) applyStimulus(1'b1, rndOp(), rndBit(), rndBit(), ctrl_t'(0), "reset");

    // R-type with no wait states: fetch lanes 1,2,4,8, then decode, execute and writeback.
    runInstr(OP_RTYPE, 0, 0, -1);
    // LB with three wait cycles on the data read.
    runInstr(OP_LB, 0, 3, -1);
    // Both outcomes of each branch.
    runInstr(OP_BEQ, 0, 0, 1);
    runInstr(OP_BEQ, 0, 0, 0);
    runInstr(OP_BNE, 0, 0, 0);
    runInstr(OP_BNE, 0, 0, 1);
    runInstr(OP_J, 0, 0, -1);
    runInstr(OP_ADDI, 0, 0, -1);
    runInstr(OP_SB, 0, 2, -1);
    // Two wait cycles on fetch beat 2, so that lane is neither skipped nor repeated.
    doFetch(2, 2, 0);
    doDecode(OP_RTYPE);
    doExecute(OP_RTYPE, 0, -1);
    // Reset during a store wait state. The next fetch restarts at lane 0.
    doFetch(-1, 0, 0);
    doDecode(OP_SB);
    e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
    applyStimulus(1'b0, OP_SB, rndBit(), rndBit(), e, "memadr");
    e = '0; e.memwrite = 1'b1; e.iord = 1'b1;
    applyStimulus(1'b0, OP_SB, rndBit(), 1'b0, e, "sbWait");
    applyStimulus(1'b1, OP_SB, rndBit(), 1'b1, ctrl_t'(0), "sbReset");
    runInstr(OP_RTYPE, 0, 0, -1);
    // Unknown opcode
    runInstr(6'b111111, 0, 0, -1);
    runInstr(OP_J, 0, 0, -1);

    // Randomised instruction stream with fetch and memory wait states
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(7, 0) == 0) opv = rndOp();
      else opv = opTable[$urandom_range(6, 0)];
      runInstr(opv, 2, int'($urandom_range(3, 0)), -1);
      if (!isKnown(opv) && $urandom_range(1, 0) == 1) begin
        applyStimulus(1'b1, rndOp(), rndBit(), rndBit(), ctrl_t'(0), "randReset");
      end
    end

    repeat (3) @(negedge clk);
    nChecks++;
    if (expQ.size() != 0) begin
      nFails++;
      $display("[TB] FAIL drain: got %0d unchecked entries, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
